// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch sequencer.
//   OPC_HALT         opcode that stops fetching once decode accepts it
//   OPC_MSB/OPC_LSB  opcode field bounds inside the instruction word
//   fetch_state_t    sequencer states
package fetch_pkg;

  localparam logic [5:0] OPC_HALT = 6'b111111;
  localparam int         OPC_MSB  = 31;
  localparam int         OPC_LSB  = 26;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: 2-entry FIFO that absorbs the memory read latency.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   i_push/i_push_data  write an entry
//   i_pop          remove the head entry
//   i_flush        empty the FIFO (wins over push and pop)
//   o_empty, o_count, o_head  status and head entry
module fetch_skid_buf #(
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic         o_empty,
  output logic [1:0]   o_count,
  output logic [W-1:0] o_head
);

  logic [W-1:0] r_ent0;
  logic [W-1:0] r_ent1;
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;
  logic         w_pop;
  logic         w_push;

  assign w_pop  = i_pop && (r_count != 2'd0);
  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ent0   <= '0;
      r_ent1   <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        if (r_wr_ptr) r_ent1 <= i_push_data;
        else          r_ent0 <= i_push_data;
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;
  assign o_head  = r_rd_ptr ? r_ent1 : r_ent0;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: fetch sequencer in front of a synchronous-read
// instruction memory. Owns the PC, hides the one-cycle read latency with a
// skid buffer and hands words to decode over valid/ready.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   i_start             level; IDLE/HALTED -> RUN
//   i_redirect_valid/i_redirect_pc  load new PC and flush
//   o_mem_addr          memory address (the PC)
//   i_mem_rdata         memory data, one cycle after the address
//   o_instr_valid/o_instr/o_instr_pc/i_instr_ready  decode handshake
//   o_running           state is RUN
//
// state  | meaning
// IDLE   | after reset, no fetching until start
// RUN    | fetching and delivering instructions
// HALTED | halt word accepted, waiting for start
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int            AW       = 5,
  parameter int            DW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_redirect_valid,
  input  logic [AW-1:0] i_redirect_pc,
  output logic [AW-1:0] o_mem_addr,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_instr_valid,
  output logic [DW-1:0] o_instr,
  output logic [AW-1:0] o_instr_pc,
  input  logic          i_instr_ready,
  output logic          o_running
);

  fetch_state_t     r_state;
  fetch_state_t     w_state_nxt;
  logic [AW-1:0]    r_pc;
  logic [AW-1:0]    r_inflight_pc;
  logic             r_inflight;
  logic             w_empty;
  logic [1:0]       w_count;
  logic [DW+AW-1:0] w_head;
  logic [DW-1:0]    w_head_instr;
  logic [AW-1:0]    w_head_pc;
  logic             w_pop;
  logic             w_halt_acc;
  logic             w_flush;
  logic             w_issue;
  logic [2:0]       w_occupancy;
  logic [2:0]       w_limit;

  assign w_head_instr = w_head[DW+AW-1:AW];
  assign w_head_pc    = w_head[AW-1:0];

  assign w_pop      = !w_empty && i_instr_ready;
  assign w_halt_acc = w_pop && (r_state == RUN) &&
                      (w_head_instr[OPC_MSB:OPC_LSB] == OPC_HALT);
  assign w_flush    = i_redirect_valid || w_halt_acc;

  // count + inflight - pop < 2, rearranged to stay non-negative.
  assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight};
  assign w_limit     = 3'd2 + {2'b00, w_pop};
  assign w_issue     = (r_state == RUN) && !w_flush && (w_occupancy < w_limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // A redirect never changes state, even when it meets start or a halt word.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, HALTED: if (i_start && !i_redirect_valid) w_state_nxt = RUN;
      RUN:          if (w_halt_acc && !i_redirect_valid) w_state_nxt = HALTED;
      default:      w_state_nxt = IDLE;
    endcase
  end

  // On halt the PC rewinds to just past the halt word, discarding any
  // addresses already issued behind it, so a later start resumes there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      if (i_redirect_valid) r_pc <= i_redirect_pc;
      else if (w_halt_acc)  r_pc <= w_head_pc + AW'(1);
      else if (w_issue)     r_pc <= r_pc + AW'(1);
      r_inflight <= w_issue;
      if (w_issue) r_inflight_pc <= r_pc;
    end
  end

  fetch_skid_buf #(
    .W (DW + AW)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_inflight && !w_flush),
    .i_push_data ({i_mem_rdata, r_inflight_pc}),
    .i_pop       (w_pop),
    .i_flush     (w_flush),
    .o_empty     (w_empty),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  assign o_mem_addr    = r_pc;
  assign o_instr_valid = !w_empty;
  assign o_instr       = w_head_instr;
  assign o_instr_pc    = w_head_pc;
  assign o_running     = (r_state == RUN);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl with a synchronous memory model.
module tb_instr_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic        i_redirect_valid;
  logic [4:0]  i_redirect_pc;
  logic [4:0]  o_mem_addr;
  logic [31:0] i_mem_rdata;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [4:0]  o_instr_pc;
  logic        i_instr_ready;
  logic        o_running;

  logic [31:0] mem [32];

  typedef struct packed {
    logic [4:0]  pc;
    logic [31:0] instr;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [4:0] tgt;
    logic [4:0] exp_first;
    int         n;
  } redir_vec_t;
  redir_vec_t vecs[3];

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch_ctrl #(
    .AW       (5),
    .DW       (32),
    .RESET_PC (5'd0)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_start          (i_start),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_mem_addr       (o_mem_addr),
    .i_mem_rdata      (i_mem_rdata),
    .o_instr_valid    (o_instr_valid),
    .o_instr          (o_instr),
    .o_instr_pc       (o_instr_pc),
    .i_instr_ready    (i_instr_ready),
    .o_running        (o_running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) i_mem_rdata <= mem[o_mem_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare every accepted word against the scoreboard front.
  task automatic mon();
    sb_t e;
    if (o_instr_valid && i_instr_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_word: got pc %0d expected no word", o_instr_pc);
      end else begin
        e = sb_q.pop_front();
        chk("sb_instr", o_instr, e.instr);
        chk("sb_pc", {27'd0, o_instr_pc}, {27'd0, e.pc});
      end
    end
  endtask

  // Called at #1 after a rising edge: drive, check, advance one cycle.
  task automatic cyc(input logic st, input logic rv, input logic [4:0] rpc, input logic rdy);
    i_start          = st;
    i_redirect_valid = rv;
    i_redirect_pc    = rpc;
    i_instr_ready    = rdy;
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input logic [4:0] first, input int n);
    logic [4:0] p;
    sb_t e;
    p = first;
    for (int k = 0; k < n; k++) begin
      e.pc    = p;
      e.instr = mem[p];
      sb_q.push_back(e);
      p = p + 5'd1;
    end
  endtask

  // First word must show up exactly in the third cycle after the command.
  task automatic lat_check(input logic [4:0] exp_pc, input string nm);
    for (int k = 1; k <= 3; k++) begin
      chk({nm, "_lat_valid"}, {31'd0, o_instr_valid}, (k == 3) ? 32'd1 : 32'd0);
      if (k == 3) chk({nm, "_first_pc"}, {27'd0, o_instr_pc}, {27'd0, exp_pc});
      cyc(1'b0, 1'b0, 5'd0, 1'b1);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb_q.size() > 0 && g < 60) begin
      chk("thru_valid", {31'd0, o_instr_valid}, 32'd1);
      cyc(1'b0, 1'b0, 5'd0, 1'b1);
      g++;
    end
    if (sb_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d words left expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    vecs[0] = '{tgt: 5'd20, exp_first: 5'd20, n: 4};
    vecs[1] = '{tgt: 5'd29, exp_first: 5'd29, n: 5};
    vecs[2] = '{tgt: 5'd3,  exp_first: 5'd3,  n: 3};
    for (int i = 0; i < 32; i++) mem[i] = 32'(i);

    rst_n            = 1'b0;
    i_start          = 1'b0;
    i_redirect_valid = 1'b0;
    i_redirect_pc    = 5'd0;
    i_instr_ready    = 1'b0;

    #2;
    chk("rst_mem_addr", {27'd0, o_mem_addr}, 32'd0);
    chk("rst_valid", {31'd0, o_instr_valid}, 32'd0);
    chk("rst_instr", o_instr, 32'd0);
    chk("rst_instr_pc", {27'd0, o_instr_pc}, 32'd0);
    chk("rst_running", {31'd0, o_running}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    repeat (3) begin
      chk("idle_valid", {31'd0, o_instr_valid}, 32'd0);
      chk("idle_running", {31'd0, o_running}, 32'd0);
      cyc(1'b0, 1'b0, 5'd0, 1'b1);
    end

    // start and stream at full rate
    push_words(5'd0, 10);
    cyc(1'b1, 1'b0, 5'd0, 1'b1);
    chk("start_running", {31'd0, o_running}, 32'd1);
    lat_check(5'd0, "start");
    drain();

    // 5-cycle stall: head holds word 10, then the stream continues
    repeat (5) begin
      chk("stall_instr", o_instr, mem[10]);
      chk("stall_pc", {27'd0, o_instr_pc}, 32'd10);
      cyc(1'b0, 1'b0, 5'd0, 1'b0);
    end
    push_words(5'd10, 10);
    drain();

    // redirects over stalled, stale contents (incl. 31 -> 0 wrap)
    for (int v = 0; v < 3; v++) begin
      cyc(1'b0, 1'b0, 5'd0, 1'b0);
      cyc(1'b0, 1'b0, 5'd0, 1'b0);
      cyc(1'b0, 1'b1, vecs[v].tgt, 1'b0);
      push_words(vecs[v].tgt, vecs[v].n);
      lat_check(vecs[v].exp_first, "redir");
      drain();
    end

    // halt word at address 2
    mem[2] = {6'b111111, 26'd2};
    cyc(1'b0, 1'b1, 5'd0, 1'b0);
    push_words(5'd0, 3);
    lat_check(5'd0, "halt_redir");
    drain();
    chk("halt_running", {31'd0, o_running}, 32'd0);
    repeat (5) begin
      chk("halt_no_valid", {31'd0, o_instr_valid}, 32'd0);
      cyc(1'b0, 1'b0, 5'd0, 1'b1);
    end
    push_words(5'd3, 3);
    cyc(1'b1, 1'b0, 5'd0, 1'b1);
    lat_check(5'd3, "resume");
    drain();

    // halt word accepted in the same cycle as a redirect: stays RUN
    cyc(1'b0, 1'b0, 5'd0, 1'b0);
    cyc(1'b0, 1'b1, 5'd2, 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 1'b0);
    chk("hr_head_pc", {27'd0, o_instr_pc}, 32'd2);
    push_words(5'd2, 1);
    cyc(1'b0, 1'b1, 5'd10, 1'b1);
    chk("hr_running", {31'd0, o_running}, 32'd1);
    push_words(5'd10, 3);
    lat_check(5'd10, "hr");
    drain();

    // asynchronous reset mid-stream
    cyc(1'b0, 1'b0, 5'd0, 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 1'b0);
    chk("pre_rst_valid", {31'd0, o_instr_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_mem_addr", {27'd0, o_mem_addr}, 32'd0);
    chk("arst_valid", {31'd0, o_instr_valid}, 32'd0);
    chk("arst_instr", o_instr, 32'd0);
    chk("arst_instr_pc", {27'd0, o_instr_pc}, 32'd0);
    chk("arst_running", {31'd0, o_running}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      chk("post_rst_valid", {31'd0, o_instr_valid}, 32'd0);
      chk("post_rst_addr", {27'd0, o_mem_addr}, 32'd0);
      cyc(1'b0, 1'b0, 5'd0, 1'b1);
    end
    push_words(5'd0, 3);
    cyc(1'b1, 1'b0, 5'd0, 1'b1);
    lat_check(5'd0, "restart");
    drain();
    chk("restart_halted", {31'd0, o_running}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
